fetch_queue: RTL

- Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word addresses to the synchronous instruction memory, which has 1-cycle read latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode.
- Absorbs decode stalls (hazard unit), branch/jump redirects (branch unit) and halt without losing or duplicating instructions.

---
 rtl/fetch_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front-end sitting ahead of the IF/ID register.
// Owns the fetch PC, issues word fetches to a 1-cycle-latency synchronous imem,
// buffers returned instructions with their PCs in a small FIFO and presents the
// head to decode. Absorbs decode stalls, branch/jump redirects and halt.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   stall        decode stall: hold the head, do not dequeue
//   redirect     taken branch/jump: flush FIFO and in-flight fetch
//   redirect_pc  redirect target (bits [1:0] forced to 00)
//   halt         stop issuing new fetches (FIFO keeps draining)
//   imem_en      fetch request this cycle
//   imem_addr    fetch address (current fetch PC)
//   imem_rdata   instruction for the request issued last cycle
//   if_valid     head entry valid
//   if_pc        PC of head entry (0 when empty)
//   if_instr     instruction of head entry (0 when empty)
//   halted       halted, FIFO empty and nothing in flight
module fetch_queue #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned INS_W = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             halt,
    output logic             imem_en,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             if_valid,
    output logic [PC_W-1:0]  if_pc,
    output logic [INS_W-1:0] if_instr,
    output logic             halted
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // Occupancy (count + inflight) needs one extra bit over count.
    localparam logic [CntW:0] DepthOcc = DEPTH[CntW:0];

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   req_pc_q;
    logic              inflight_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [CntW-1:0]   count_q;

    logic [PC_W-1:0]   pc_mem  [DEPTH];
    logic [INS_W-1:0]  ins_mem [DEPTH];

    logic [CntW:0]     occupancy;
    logic              issue;
    logic              push;
    logic              pop;

    // Conservative credit: a same-cycle dequeue is not counted as free space.
    assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    assign issue     = (state_q == StRun) && !halt && !redirect && (occupancy < DepthOcc);
    // Redirect kills the in-flight response and any dequeue in the same cycle.
    assign push      = inflight_q && !redirect;
    assign pop       = (count_q != '0) && !stall && !redirect;

    assign imem_en   = issue;
    assign imem_addr = pc_q;
    assign if_valid  = (count_q != '0);
    assign if_pc     = if_valid ? pc_mem[rd_ptr_q]  : '0;
    assign if_instr  = if_valid ? ins_mem[rd_ptr_q] : '0;
    assign halted    = (state_q == StHalt) && (count_q == '0) && !inflight_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            // Halt wins the next state even alongside a redirect; the target
            // is still loaded into the fetch PC so resume is correct.
            state_q <= halt ? StHalt : StRun;

            if (redirect) begin
                pc_q       <= {redirect_pc[PC_W-1:2], 2'b00};
                inflight_q <= 1'b0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                if (issue) begin
                    pc_q     <= pc_q + PC_W'(4);
                    req_pc_q <= pc_q;
                end
                inflight_q <= issue;
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
                count_q <= count_q + CntW'(push) - CntW'(pop);
            end
        end
    end

    // Storage needs no reset: head outputs are masked while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= req_pc_q;
            ins_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
